// File: rtl/ray_frame_scheduler.sv
// Frame scheduler: walks pixels in raster order, issues rays under a
// credit limit and tags in-order results with their pixel coordinates.
module ray_frame_scheduler #(
  parameter int              WIDTH        = 640,
  parameter int              HEIGHT       = 480,
  parameter int              X_W          = 10,
  parameter int              Y_W          = 9,
  parameter int              FP_W         = 32,
  parameter logic [FP_W-1:0] STEP         = 32'h0000_0111,
  parameter int              MAX_INFLIGHT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            ray_valid,
  output logic [FP_W-1:0] screen_x,
  output logic [FP_W-1:0] screen_y,
  input  logic            ray_done,
  input  logic            ray_hit,
  output logic            pix_valid,
  output logic [X_W-1:0]  pix_x,
  output logic [Y_W-1:0]  pix_y,
  output logic            pix_hit,
  output logic            busy,
  output logic            frame_done,
  output logic            tag_err
);

  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int TW = X_W + Y_W;

  localparam logic [FP_W-1:0] X0 =
    '0 - FP_W'(WIDTH / 2) * STEP;
  localparam logic [FP_W-1:0] Y0 =
    FP_W'(HEIGHT / 2) * STEP;

  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);
  localparam logic [CW-1:0]  MAX_C  = CW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [X_W-1:0]  px;
  logic [Y_W-1:0]  py;
  logic [FP_W-1:0] x_acc;
  logic [FP_W-1:0] y_acc;
  logic [CW-1:0]   inflight;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [TW-1:0]   tag_mem [MAX_INFLIGHT];

  logic pop;
  logic issue;
  logic last_pix;

  // A same-cycle return frees a credit, so a full window can still issue
  assign pop      = ray_done && (inflight != '0);
  assign issue    = (state == ISSUE) && !abort &&
                    ((inflight < MAX_C) || pop);
  assign last_pix = (px == X_LAST) && (py == Y_LAST);

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: begin
        if (abort)                 state_nx = DRAIN;
        else if (issue && last_pix) state_nx = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0 && !ray_done)
          state_nx = DONE;
      end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px    <= '0;
      py    <= '0;
      x_acc <= '0;
      y_acc <= '0;
    end else if (state == IDLE && start) begin
      px    <= '0;
      py    <= '0;
      x_acc <= X0;
      y_acc <= Y0;
    end else if (issue) begin
      if (px != X_LAST) begin
        px    <= px + X_W'(1);
        x_acc <= x_acc + STEP;
      end else begin
        px    <= '0;
        x_acc <= X0;
        py    <= py + Y_W'(1);
        y_acc <= y_acc - STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ray_valid <= 1'b0;
      screen_x  <= '0;
      screen_y  <= '0;
    end else begin
      ray_valid <= issue;
      if (issue) begin
        screen_x <= x_acc;
        screen_y <= y_acc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= {px, py};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (issue && !pop)      inflight <= inflight + CW'(1);
      else if (!issue && pop) inflight <= inflight - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_hit   <= 1'b0;
      tag_err   <= 1'b0;
    end else begin
      pix_valid <= pop;
      if (pop) begin
        {pix_x, pix_y} <= tag_mem[rd_ptr];
        pix_hit        <= ray_hit;
      end
      if (ray_done && inflight == '0) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Bench for ray_frame_scheduler: directed frame scenarios with random
// return delays and hit flags, checked against a pixel-level model.
module tb_ray_frame_scheduler;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int XW    = 2;
  localparam int YW    = 1;
  localparam int STEPI = 65536;
  localparam int MAXI  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic            ray_valid;
  logic [31:0]     screen_x;
  logic [31:0]     screen_y;
  logic            ray_done;
  logic            ray_hit;
  logic            pix_valid;
  logic [XW-1:0]   pix_x;
  logic [YW-1:0]   pix_y;
  logic            pix_hit;
  logic            busy;
  logic            frame_done;
  logic            tag_err;

  ray_frame_scheduler #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .X_W         (XW),
    .Y_W         (YW),
    .FP_W        (32),
    .STEP        (32'h0001_0000),
    .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .ray_valid (ray_valid),
    .screen_x  (screen_x),
    .screen_y  (screen_y),
    .ray_done  (ray_done),
    .ray_hit   (ray_hit),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_hit   (pix_hit),
    .busy      (busy),
    .frame_done(frame_done),
    .tag_err   (tag_err)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // pixel-level model state
  int  pq[$];
  int  due_q[$];
  int  outst   = 0;
  int  issued  = 0;
  bit  issuing = 0;
  bit  active  = 0;
  bit  tag_m   = 0;
  bit  fd_exp  = 0;
  bit  fd_obs  = 0;
  bit  ret_en  = 1;
  bit  stray   = 0;
  int  dly_lo  = 1;
  int  dly_hi  = 1;
  int  nrv     = 0;
  int  npix    = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit rd;
    bit rh;
    bit st_s;
    bit ab_s;
    bit pop;
    bit exp_rv;
    int k;
    rd = stray;
    if (ret_en && due_q.size() > 0 && due_q[0] <= cyc + 1) begin
      rd = 1'b1;
      void'(due_q.pop_front());
    end
    rh       = 1'($urandom_range(0, 1));
    ray_done = rd;
    ray_hit  = rh;
    st_s     = start;
    ab_s     = abort;
    @(posedge clk);
    #1;
    cyc++;
    ray_done = 1'b0;
    pop    = rd && (outst > 0);
    exp_rv = issuing && !ab_s && (outst < MAXI || pop);
    chk("ray_valid", 32'(ray_valid), 32'(exp_rv));
    chk("pix_valid", 32'(pix_valid), 32'(pop));
    if (ray_valid === 1'b1) nrv++;
    if (pop) begin
      k = pq.pop_front();
      npix++;
      chk("pix_x", 32'(pix_x), k % W);
      chk("pix_y", 32'(pix_y), k / W);
      chk("pix_hit", 32'(pix_hit), 32'(rh));
    end
    if (rd && outst == 0) tag_m = 1'b1;
    chk("tag_err", 32'(tag_err), 32'(tag_m));
    chk("frame_done", 32'(frame_done), 32'(fd_exp));
    fd_obs = (frame_done === 1'b1);
    outst -= int'(pop);
    if (exp_rv && ray_valid === 1'b1) begin
      chk("screen_x", screen_x,
          32'((issued % W - W / 2) * STEPI));
      chk("screen_y", screen_y,
          32'((H / 2 - issued / W) * STEPI));
    end
    if (exp_rv) begin
      pq.push_back(issued);
      due_q.push_back(cyc + int'($urandom_range(dly_hi, dly_lo)));
      issued++;
      outst++;
      if (issued == W * H) issuing = 1'b0;
    end
    if (ab_s && issuing) issuing = 1'b0;
    if (st_s && !active) begin
      active  = 1'b1;
      issuing = 1'b1;
      issued  = 0;
    end
    chk("busy", 32'(busy), 32'(active));
    if (fd_exp) active = 1'b0;
    fd_exp = active && !issuing && outst == 0;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 400 && !fd_obs; i++) tick();
    chk("frame_end", 32'(fd_obs), 32'd1);
    fd_obs = 1'b0;
    tick();
    chk("busy_after", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic begin_frame();
    nrv   = 0;
    npix  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    ray_done = 1'b0;
    ray_hit  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ray_valid", 32'(ray_valid), 32'd0);
    chk("rst_screen_x", screen_x, 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_tag_err", 32'(tag_err), 32'd0);
    rst = 1'b0;

    // full frame, fixed return latency
    dly_lo = 5;
    dly_hi = 5;
    begin_frame();
    wait_frame();
    chk("a_rays", nrv, W * H);
    chk("a_pix", npix, W * H);

    // credit stall, then one return per cycle against a full window
    dly_lo = 1;
    dly_hi = 1;
    ret_en = 1'b0;
    begin_frame();
    repeat (10) tick();
    chk("stall_cnt", nrv, MAXI);
    chk("stall_busy", 32'(busy), 32'd1);
    ret_en = 1'b1;
    wait_frame();
    chk("b_rays", nrv, W * H);

    // abort after three issues, slow returns
    dly_lo = 10;
    dly_hi = 10;
    begin_frame();
    for (int i = 0; i < 20 && nrv < 3; i++) tick();
    abort = 1'b1;
    wait_frame();
    abort = 1'b0;
    chk("abort_rays", nrv, 3);
    chk("abort_pix", npix, 3);

    // stray result while idle
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("stray_tag_err", 32'(tag_err), 32'd1);
    tick();

    // random latencies, start ignored while busy
    dly_lo = 1;
    dly_hi = 7;
    begin_frame();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_frame();
    chk("d_rays", nrv, W * H);
    chk("d_tag_err", 32'(tag_err), 32'd1);

    // asynchronous reset with three rays outstanding
    ret_en = 1'b0;
    begin_frame();
    for (int i = 0; i < 20 && nrv < 3; i++) tick();
    rst = 1'b1;
    #1;
    chk("arst_ray_valid", 32'(ray_valid), 32'd0);
    chk("arst_screen_x", screen_x, 32'd0);
    chk("arst_screen_y", screen_y, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tag_err", 32'(tag_err), 32'd0);
    chk("arst_pix_valid", 32'(pix_valid), 32'd0);
    pq.delete();
    due_q.delete();
    outst   = 0;
    issued  = 0;
    issuing = 1'b0;
    active  = 1'b0;
    tag_m   = 1'b0;
    fd_exp  = 1'b0;
    fd_obs  = 1'b0;
    #1;
    rst    = 1'b0;
    ret_en = 1'b1;
    tick();

    // clean frame after reset
    dly_lo = 1;
    dly_hi = 9;
    begin_frame();
    wait_frame();
    chk("e_rays", nrv, W * H);
    chk("e_tag_err", 32'(tag_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
